uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO. Frame configuration (divisor, parity, stop bits)
// is captured when a word is popped and held for the whole frame.
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst_L,
   input  logic [DIV_W-1:0]            i_Clks_Per_Bit,
   input  logic [1:0]                  i_Parity_Mode,
   input  logic                        i_Two_Stop,
   input  logic                        i_TX_Valid,
   input  logic [DATA_W-1:0]           i_TX_Data,
   output logic                        o_TX_Ready,
   output logic                        o_TX_Serial,
   output logic                        o_TX_Active,
   output logic                        o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_W - 1);
   localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // ---------------- FIFO ----------------
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_n;
   logic              tx_ready, push, pop, fifo_nonempty;

   assign push          = i_TX_Valid && tx_ready;
   assign fifo_nonempty = (count != '0);

   always_comb begin
      count_n = count;
      if (push && !pop)
         count_n = count + CW'(1);
      else if (pop && !push)
         count_n = count - CW'(1);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tx_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count    <= count_n;
         tx_ready <= (count_n < DEPTH_C);
      end
   end

   // NOTE: storage is deliberately unreset; pointers and count alone define which entries are valid.
   always_ff @(posedge i_Clock) begin
      if (push) mem[wr_ptr] <= i_TX_Data;
   end

   // ---------------- Transmit FSM ----------------
   state_t            state_q, state_n;
   logic [DIV_W-1:0]  clk_cnt, clk_cnt_n, div_q, div_n;
   logic [BW-1:0]     bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [1:0]        pmode_q, pmode_n;
   logic              two_q, two_n, par_acc, par_acc_n;
   logic              serial_q, serial_n, active_q, active_n, done_q, done_n;
   logic              bit_end, par_en, load;

   assign bit_end = (clk_cnt == div_q - DIV_W'(1));
   assign par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);

   always_comb begin
      state_n   = state_q;
      clk_cnt_n = clk_cnt + DIV_W'(1);
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_acc_n = par_acc;
      div_n     = div_q;
      pmode_n   = pmode_q;
      two_n     = two_q;
      done_n    = 1'b0;
      load      = 1'b0;
      pop       = 1'b0;
      serial_n  = 1'b1;

      case (state_q)
         IDLE: begin
            clk_cnt_n = '0;
            load      = fifo_nonempty;
         end
         START: if (bit_end) begin
            clk_cnt_n = '0;
            state_n   = DATA;
         end
         DATA: if (bit_end) begin
            clk_cnt_n = '0;
            par_acc_n = par_acc ^ shreg[0];
            shreg_n   = shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt_n = '0;
               state_n   = par_en ? PARITY : STOP;
            end else begin
               bit_cnt_n = bit_cnt + BW'(1);
            end
         end
         PARITY: if (bit_end) begin
            clk_cnt_n = '0;
            state_n   = STOP;
         end
         STOP: if (bit_end) begin
            clk_cnt_n = '0;
            if (two_q && bit_cnt == '0) begin
               bit_cnt_n = BW'(1);
            end else begin
               done_n  = 1'b1;
               state_n = IDLE;
               load    = fifo_nonempty;
            end
         end
         default: begin
            state_n   = IDLE;
            clk_cnt_n = '0;
         end
      endcase

      // Popping in the last stop clock lets the next start bit follow with no idle gap.
      if (load) begin
         pop       = 1'b1;
         state_n   = START;
         clk_cnt_n = '0;
         bit_cnt_n = '0;
         shreg_n   = mem[rd_ptr];
         par_acc_n = 1'b0;
         div_n     = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
         pmode_n   = i_Parity_Mode;
         two_n     = i_Two_Stop;
      end

      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shreg_n[0];
         PARITY:  serial_n = par_acc_n ^ (pmode_n == 2'b10);
         default: serial_n = 1'b1;
      endcase
      active_n = (state_n != IDLE);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= IDLE;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_acc  <= 1'b0;
         div_q    <= MIN_DIV;
         pmode_q  <= 2'b00;
         two_q    <= 1'b0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         clk_cnt  <= clk_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_acc  <= par_acc_n;
         div_q    <= div_n;
         pmode_q  <= pmode_n;
         two_q    <= two_n;
         serial_q <= serial_n;
         active_q <= active_n;
         done_q   <= done_n;
      end
   end

   assign o_TX_Ready   = tx_ready;
   assign o_FIFO_Count = count;
   assign o_TX_Serial  = serial_q;
   assign o_TX_Active  = active_q;
   assign o_TX_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, parity, stop bits, FIFO full,
// back-to-back frames, per-frame divisor capture and asynchronous reset.
module tb_uart_tx_fifo;

   logic        clk;
   logic        rst_l;
   logic [15:0] clks_per_bit;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready, tx_serial, tx_active, tx_done;
   logic [2:0]  fifo_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
      .i_Clock        (clk),
      .i_Rst_L        (rst_l),
      .i_Clks_Per_Bit (clks_per_bit),
      .i_Parity_Mode  (parity_mode),
      .i_Two_Stop     (two_stop),
      .i_TX_Valid     (tx_valid),
      .i_TX_Data      (tx_data),
      .o_TX_Ready     (tx_ready),
      .o_TX_Serial    (tx_serial),
      .o_TX_Active    (tx_active),
      .o_TX_Done      (tx_done),
      .o_FIFO_Count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (tx_serial !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, " start"}, 32'(tx_serial), 32'd0);
   endtask

   // Called on the first start-bit sample; returns on the sample after the last stop clock.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                              input int div);
      int errs = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < div; c++) begin
            if (tx_serial !== bits[i] || tx_active !== 1'b1) errs++;
            if ((i != 0 || c != 0) && tx_done !== 1'b0) errs++;
            @(negedge clk);
         end
      end
      check({tag, " bits"}, 32'(errs), 32'd0);
      check({tag, " done"}, 32'(tx_done), 32'd1);
   endtask

   initial begin
      int errs;
      int n;
      rst_l        = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      clks_per_bit = 16'd4;
      parity_mode  = 2'b00;
      two_stop     = 1'b0;

      // Reset takes effect before any clock edge
      #2 rst_l = 1'b0;
      #1;
      check("rst line",   32'(tx_serial),  32'd1);
      check("rst active", 32'(tx_active),  32'd0);
      check("rst done",   32'(tx_done),    32'd0);
      check("rst ready",  32'(tx_ready),   32'd1);
      check("rst count",  32'(fifo_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);

      // 0xA5, 8N1, divisor 4: push-to-start latency then full frame
      push(8'hA5);
      check("lat1 line",  32'(tx_serial),  32'd1);
      check("lat1 count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      check("lat2 line",  32'(tx_serial),  32'd0);
      check("lat2 count", 32'(fifo_count), 32'd0);
      check_frame("a5 8n1", 16'h034A, 10, 4);
      check("a5 end active", 32'(tx_active), 32'd0);
      @(negedge clk);
      check("a5 done width", 32'(tx_done),   32'd0);
      check("a5 idle line",  32'(tx_serial), 32'd1);

      // Parity and stop-bit variants
      parity_mode = 2'b01;
      push(8'hA5);
      wait_start("even");
      check_frame("a5 even", 16'h054A, 11, 4);
      parity_mode = 2'b10;
      push(8'hA5);
      wait_start("odd");
      check_frame("a5 odd", 16'h074A, 11, 4);
      two_stop = 1'b1;
      push(8'hA5);
      wait_start("odd2");
      check_frame("a5 odd 2stop", 16'h0F4A, 12, 4);
      parity_mode = 2'b00;
      push(8'hA5);
      wait_start("none2");
      check_frame("a5 none 2stop", 16'h074A, 11, 4);
      two_stop    = 1'b0;
      parity_mode = 2'b11;
      push(8'hA5);
      wait_start("mode3");
      check_frame("a5 mode3", 16'h034A, 10, 4);
      parity_mode = 2'b00;

      // Three queued words go out back to back
      fork
         begin
            push(8'h3C);
            push(8'h81);
            push(8'h00);
         end
         begin
            wait_start("b2b");
            check_frame("b2b f1", 16'h0278, 10, 4);
            check("b2b active1", 32'(tx_active), 32'd1);
            check_frame("b2b f2", 16'h0302, 10, 4);
            check("b2b active2", 32'(tx_active), 32'd1);
            check_frame("b2b f3", 16'h0200, 10, 4);
            check("b2b active end", 32'(tx_active), 32'd0);
         end
      join

      // Divisor change mid-frame only affects the following frame
      fork
         begin
            push(8'hA5);
            repeat (6) @(negedge clk);
            clks_per_bit = 16'd8;
            push(8'h3C);
         end
         begin
            wait_start("div");
            check_frame("div4 current", 16'h034A, 10, 4);
            check_frame("div8 next",    16'h0278, 10, 8);
            check("div end active", 32'(tx_active), 32'd0);
         end
      join

      // FIFO full while a slow frame stalls the line; drain at divisor 0 (=2)
      clks_per_bit = 16'd200;
      push(8'h55);
      wait_start("stall");
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      check("full ready", 32'(tx_ready),   32'd0);
      check("full count", 32'(fifo_count), 32'd4);
      push(8'h99);
      push(8'hEE);
      check("drop ready", 32'(tx_ready),   32'd0);
      check("drop count", 32'(fifo_count), 32'd4);
      clks_per_bit = 16'd0;
      n = 0;
      while (tx_done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("stall done", 32'(tx_done), 32'd1);
      check_frame("drain 11", 16'h0222, 10, 2);
      check_frame("drain 22", 16'h0244, 10, 2);
      check_frame("drain 33", 16'h0266, 10, 2);
      check_frame("drain 44", 16'h0288, 10, 2);
      check("drain active", 32'(tx_active), 32'd0);
      repeat (20) @(negedge clk);
      check("drain idle line", 32'(tx_serial),  32'd1);
      check("drain count",     32'(fifo_count), 32'd0);
      check("drain ready",     32'(tx_ready),   32'd1);

      // Asynchronous reset in the middle of a data bit with two words queued
      clks_per_bit = 16'd4;
      push(8'hA5);
      push(8'h3C);
      push(8'h81);
      repeat (8) @(negedge clk);
      check("pre-rst line",  32'(tx_serial),  32'd0);
      check("pre-rst count", 32'(fifo_count), 32'd2);
      #2 rst_l = 1'b0;
      #1;
      check("mid-rst line",   32'(tx_serial),  32'd1);
      check("mid-rst active", 32'(tx_active),  32'd0);
      check("mid-rst count",  32'(fifo_count), 32'd0);
      check("mid-rst ready",  32'(tx_ready),   32'd1);
      check("mid-rst done",   32'(tx_done),    32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      errs  = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_done !== 1'b0 || tx_active !== 1'b0) errs++;
      end
      check("post-rst quiet", 32'(errs),       32'd0);
      check("post-rst count", 32'(fifo_count), 32'd0);
      push(8'h81);
      wait_start("resume");
      check_frame("resume 81", 16'h0302, 10, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
